// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: Clk/2 pixel enable, 10-bit column/line counters, registered syncs.
// Optional 8-bit frame counter output when VGA_SCAN_FRAME_COUNT_EN is defined.
module vga_scan_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       VGA_CLK,
    output logic       pixel_ce,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_SCAN_FRAME_COUNT_EN
    ,
    output logic [7:0] frame_count
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic       phase_reg;
    logic [9:0] x_reg;
    logic [9:0] y_reg;
    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       hs_reg;
    logic       vs_reg;
    logic       blank_n_reg;
    logic       line_start_reg;
    logic       frame_start_reg;
    logic       line_wrap;
    logic       frame_wrap;

    assign line_wrap  = phase_reg && (x_reg == H_MAX);
    assign frame_wrap = line_wrap && (y_reg == V_MAX);

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (phase_reg) begin
            if (x_reg == H_MAX) begin
                x_next = 10'd0;
                y_next = (y_reg == V_MAX) ? 10'd0 : y_reg + 10'd1;
            end else begin
                x_next = x_reg + 10'd1;
            end
        end
    end

    // Sync and blank are derived from the next counter values so they
    // update on the very edge the counters do.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            phase_reg       <= 1'b0;
            x_reg           <= 10'd0;
            y_reg           <= 10'd0;
            hs_reg          <= 1'b1;
            vs_reg          <= 1'b1;
            blank_n_reg     <= 1'b1;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            phase_reg       <= ~phase_reg;
            x_reg           <= x_next;
            y_reg           <= y_next;
            hs_reg          <= !((x_next >= HS_START) && (x_next < HS_END));
            vs_reg          <= !((y_next >= VS_START) && (y_next < VS_END));
            blank_n_reg     <= (x_next < H_VIS_END) && (y_next < V_VIS_END);
            line_start_reg  <= line_wrap;
            frame_start_reg <= frame_wrap;
        end
    end

`ifdef VGA_SCAN_FRAME_COUNT_EN
    logic [7:0] frame_count_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_count_reg <= 8'd0;
        end else if (frame_wrap) begin
            frame_count_reg <= frame_count_reg + 8'd1;
        end
    end

    assign frame_count = frame_count_reg;
`endif

    assign VGA_CLK     = phase_reg;
    assign pixel_ce    = phase_reg;
    assign VGA_HS      = hs_reg;
    assign VGA_VS      = vs_reg;
    assign VGA_BLANK_N = blank_n_reg;
    assign VGA_SYNC_N  = 1'b0;
    assign DrawX       = x_reg;
    assign DrawY       = y_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: cycle scoreboard from an arithmetic timing model plus directed timing checks.
// Reduced timings keep the run short; a tiny raster is used when VGA_SCAN_FRAME_COUNT_EN is defined.
module tb_vga_scan_gen;

`ifdef VGA_SCAN_FRAME_COUNT_EN
    localparam int HV = 4,  HFP = 1, HSW = 2,  HBP = 1;
    localparam int VV = 3,  VFP = 1, VSW = 1,  VBP = 1;
`else
    localparam int HV = 64, HFP = 8, HSW = 16, HBP = 12;
    localparam int VV = 48, VFP = 3, VSW = 2,  VBP = 7;
`endif
    localparam int HT = HV + HFP + HSW + HBP;
    localparam int VT = VV + VFP + VSW + VBP;
    localparam int FRAME_CLK = 2 * HT * VT;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       VGA_CLK, pixel_ce, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic [9:0] DrawX, DrawY;
    logic       line_start, frame_start;
    logic [7:0] fc_obs;

    int checks   = 0;
    int failures = 0;

    vga_scan_gen #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
        .Clk(clk),
        .Reset(Reset),
        .VGA_CLK(VGA_CLK),
        .pixel_ce(pixel_ce),
        .VGA_HS(VGA_HS),
        .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N),
        .DrawX(DrawX),
        .DrawY(DrawY),
        .line_start(line_start),
        .frame_start(frame_start)
`ifdef VGA_SCAN_FRAME_COUNT_EN
        ,
        .frame_count(fc_obs)
`endif
    );

`ifndef VGA_SCAN_FRAME_COUNT_EN
    assign fc_obs = 8'd0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int x, input int y, input logic hs, input logic vs,
                                         input logic bl, input logic ls, input logic fs,
                                         input logic ph, input logic sync_n, input int fc);
        return {28'd0, 8'(fc), 10'(x), 10'(y), hs, vs, bl, ls, fs, ph, ph, sync_n};
    endfunction

    // Timing model: everything follows from the number of Clk edges since reset release.
    logic [63:0] sb_q[$];
    int t      = 0;
    int exp_fc = 0;

    always @(posedge clk) begin
        int p, x, y, ph;
        logic ls, fs, hs, vs, bl;
        if (Reset) begin
            t = 0;
            exp_fc = 0;
            sb_q.push_back(pack(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        end else begin
            t++;
            ph = t % 2;
            p  = t / 2;
            x  = p % HT;
            y  = (p / HT) % VT;
            ls = (ph == 0) && (x == 0);
            fs = ls && (y == 0);
            if (fs) exp_fc = (exp_fc + 1) % 256;
            hs = !((x >= HV + HFP) && (x < HV + HFP + HSW));
            vs = !((y >= VV + VFP) && (y < VV + VFP + VSW));
            bl = (x < HV) && (y < VV);
`ifdef VGA_SCAN_FRAME_COUNT_EN
            sb_q.push_back(pack(x, y, hs, vs, bl, ls, fs, 1'(ph), 1'b0, exp_fc));
`else
            sb_q.push_back(pack(x, y, hs, vs, bl, ls, fs, 1'(ph), 1'b0, 0));
`endif
        end
    end

    always @(negedge clk) begin
        logic [63:0] exp_v;
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            check("scan", {28'd0, fc_obs, DrawX, DrawY, VGA_HS, VGA_VS, VGA_BLANK_N, line_start,
                           frame_start, pixel_ce, VGA_CLK, VGA_SYNC_N}, exp_v);
        end
    end

    initial begin
        #(20 * 400000);
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ls_cnt, hs_low, hs_first_x, bl_fall_x, vs_low, fs_cnt, fs_t0, fs_t1;
        bit found;

        Reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_x", 64'(DrawX), 64'd0);
        check("rst_y", 64'(DrawY), 64'd0);
        check("rst_sync", {61'd0, VGA_HS, VGA_VS, VGA_BLANK_N}, 64'h7);
        check("rst_pulses", {62'd0, line_start, frame_start}, 64'd0);
        Reset = 1'b0;

        // Line 0: pixel advance, HS window and blanking edge.
        ls_cnt = 0; hs_low = 0; hs_first_x = -1; bl_fall_x = -1;
        for (int i = 1; i <= 2 * HT; i++) begin
            @(negedge clk);
            if (line_start) ls_cnt++;
            if (i == 1) check("x_after1", 64'(DrawX), 64'd0);
            if (i == 2) check("x_after2", 64'(DrawX), 64'd1);
            if (DrawY == 10'd0) begin
                if (!VGA_HS) begin
                    hs_low++;
                    if (hs_first_x < 0) hs_first_x = int'(DrawX);
                end
                if (!VGA_BLANK_N && bl_fall_x < 0) bl_fall_x = int'(DrawX);
            end
        end
        check("line1_x", 64'(DrawX), 64'd0);
        check("line1_y", 64'(DrawY), 64'd1);
        check("line1_ls", 64'(line_start), 64'd1);
        check("ls_count", 64'(ls_cnt), 64'd1);
        check("hs_low_clks", 64'(hs_low), 64'(2 * HSW));
        check("hs_first_x", 64'(hs_first_x), 64'(HV + HFP));
        check("blank_fall_x", 64'(bl_fall_x), 64'(HV));

        // Two full frames: VS width and frame_start spacing.
        vs_low = 0; fs_cnt = 0; fs_t0 = -1; fs_t1 = -1;
        for (int i = 2 * HT + 1; i <= 2 * FRAME_CLK; i++) begin
            @(negedge clk);
            if (i <= FRAME_CLK && !VGA_VS) vs_low++;
            if (frame_start) begin
                fs_cnt++;
                if (fs_t0 < 0) fs_t0 = i;
                else if (fs_t1 < 0) fs_t1 = i;
            end
        end
        check("vs_low_clks", 64'(vs_low), 64'(2 * VSW * HT));
        check("fs_count", 64'(fs_cnt), 64'd2);
        check("fs_first", 64'(fs_t0), 64'(FRAME_CLK));
        check("fs_spacing", 64'(fs_t1 - fs_t0), 64'(FRAME_CLK));

        // Mid-frame reset for one Clk.
        found = 1'b0;
        for (int i = 0; i < FRAME_CLK + 8 && !found; i++) begin
            @(negedge clk);
            if (DrawX == 10'(HV / 2) && DrawY == 10'(VV / 2)) found = 1'b1;
        end
        check("reach_target", 64'(found), 64'd1);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        check("midrst_x", 64'(DrawX), 64'd0);
        check("midrst_y", 64'(DrawY), 64'd0);
        check("midrst_fs", 64'(frame_start), 64'd0);
        check("midrst_ce", 64'(pixel_ce), 64'd0);
        @(negedge clk);
        check("first_ce", 64'(pixel_ce), 64'd1);
        @(negedge clk);
        check("first_adv_x", 64'(DrawX), 64'd1);

`ifdef VGA_SCAN_FRAME_COUNT_EN
        fs_cnt = 0;
        for (int i = 0; i < 258 * FRAME_CLK && fs_cnt < 256; i++) begin
            @(negedge clk);
            if (frame_start) begin
                fs_cnt++;
                if (fs_cnt == 255) check("fc_255", 64'(fc_obs), 64'd255);
                if (fs_cnt == 256) check("fc_wrap", 64'(fc_obs), 64'd0);
            end
        end
        check("fc_frames", 64'(fs_cnt), 64'd256);
`endif

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
